// File: rtl/uart_bus_master_pkg.sv
// Shared opcodes, response codes and state encodings
// for the serial debug bus master.
package uart_bus_master_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;

  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronizer, start confirm,
// mid-bit sampling and stop-bit framing check.
module uart_rx_byte
  import uart_bus_master_pkg::*;
#(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

  logic          s1, s2, s_prev;
  logic          fall;
  logic          cnt_wrap;
  logic          tick;
  rx_state_t     st, nst;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s1     <= rx;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  assign fall = s_prev & ~s2;
  assign tick = cnt == FULL;
  assign cnt_wrap = (st == RX_START) ? (cnt == HALF) : tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= RX_IDLE;
    else       st <= nst;
  end

  always_comb begin
    nst = st;
    unique case (st)
      RX_IDLE:  if (fall) nst = RX_START;
      RX_START: if (cnt == HALF) nst = s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) nst = RX_STOP;
      RX_STOP:  if (tick) nst = RX_IDLE;
      default:  nst = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (st == RX_STOP && tick) begin
      byte_valid = s2;
      frame_err  = ~s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      if (st == RX_IDLE || cnt_wrap) cnt <= '0;
      else                           cnt <= cnt + 1'b1;
      if (st == RX_START) bit_idx <= '0;
      if (st == RX_DATA && tick) begin
        sh      <= {s2, sh[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  assign byte_data = sh;

endmodule

// File: rtl/uart_bus_master.sv
// Serial command bridge issuing single 32-bit bus
// reads/writes and returning results over tx.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int CLK_DIV       = 104,
  parameter int FRAME_TIMEOUT = 100000,
  parameter int BUS_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic        valid,
  input  logic        ready,
  output logic [3:0]  wstrb,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int FW = $clog2(FRAME_TIMEOUT + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL   = CW'(CLK_DIV - 1);
  localparam logic [FW-1:0] F_MAX  = FW'(FRAME_TIMEOUT);
  localparam logic [BW-1:0] B_LAST = BW'(BUS_TIMEOUT - 1);

  logic          byte_valid;
  logic          frame_err;
  logic [7:0]    byte_data;

  state_t        st, nst;
  logic          is_wr;
  logic [1:0]    idx;
  logic [FW-1:0] gap;
  logic [BW-1:0] bcnt;
  logic          op_ok, gap_hit, bus_hit, in_frame;

  logic [9:0]    tsh;
  logic [CW-1:0] tcnt;
  logic [3:0]    tbits;
  logic [23:0]   rbuf;
  logic [1:0]    rleft;
  logic          tx_done;

  logic          tx_load;
  logic [7:0]    tx_byte;
  logic [23:0]   ld_buf;
  logic [1:0]    ld_left;

  uart_rx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign op_ok    = byte_data == OP_READ || byte_data == OP_WRITE;
  assign gap_hit  = gap == F_MAX;
  assign bus_hit  = bcnt == B_LAST;
  assign in_frame = st == ST_GET_ADDR || st == ST_GET_DATA;
  assign tx_done  = tbits == 4'd1 && tcnt == FULL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= ST_IDLE;
    else       st <= nst;
  end

  always_comb begin
    nst = st;
    unique case (st)
      ST_IDLE:
        if (byte_valid) nst = op_ok ? ST_GET_ADDR : ST_RESP;
      ST_GET_ADDR:
        if (frame_err || gap_hit) nst = ST_IDLE;
        else if (byte_valid && idx == 2'd3)
          nst = is_wr ? ST_GET_DATA : ST_BUS;
      ST_GET_DATA:
        if (frame_err || gap_hit) nst = ST_IDLE;
        else if (byte_valid && idx == 2'd3) nst = ST_BUS;
      ST_BUS:
        if (ready || bus_hit) nst = ST_RESP;
      ST_RESP:
        if (tx_done && rleft == 2'd0) nst = ST_IDLE;
      default: nst = ST_IDLE;
    endcase
  end

  // First response byte is loaded on the deciding edge so the
  // start bit appears the cycle after ready.
  always_comb begin
    tx_load = 1'b0;
    tx_byte = RSP_OK;
    ld_buf  = rbuf;
    ld_left = rleft;
    unique case (st)
      ST_IDLE:
        if (byte_valid && !op_ok) begin
          tx_load = 1'b1;
          tx_byte = RSP_BAD;
          ld_left = 2'd0;
        end
      ST_BUS:
        if (ready) begin
          tx_load = 1'b1;
          if (is_wr) begin
            tx_byte = RSP_OK;
            ld_left = 2'd0;
          end else begin
            tx_byte = rdata[7:0];
            ld_buf  = rdata[31:8];
            ld_left = 2'd3;
          end
        end else if (bus_hit) begin
          tx_load = 1'b1;
          tx_byte = RSP_ERR;
          ld_left = 2'd0;
        end
      ST_RESP:
        if (tx_done && rleft != 2'd0) begin
          tx_load = 1'b1;
          tx_byte = rbuf[7:0];
          ld_buf  = {8'h00, rbuf[23:8]};
          ld_left = rleft - 1'b1;
        end
      default: tx_load = 1'b0;
    endcase
  end

  assign valid = st == ST_BUS;
  assign wstrb = (valid && is_wr) ? 4'hF : 4'h0;
  assign busy  = st != ST_IDLE;
  assign tx    = (tbits != 4'd0) ? tsh[0] : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_wr <= 1'b0;
      idx   <= '0;
      addr  <= '0;
      wdata <= '0;
      gap   <= '0;
      bcnt  <= '0;
    end else begin
      if (st == ST_IDLE && byte_valid) begin
        is_wr <= byte_data == OP_WRITE;
        idx   <= '0;
      end
      if (st == ST_GET_ADDR && byte_valid) begin
        addr[8*idx +: 8] <= byte_data;
        idx <= idx + 1'b1;
      end
      if (st == ST_GET_DATA && byte_valid) begin
        wdata[8*idx +: 8] <= byte_data;
        idx <= idx + 1'b1;
      end
      if (!in_frame || byte_valid) gap <= '0;
      else if (!gap_hit)           gap <= gap + 1'b1;
      if (st != ST_BUS)  bcnt <= '0;
      else if (!bus_hit) bcnt <= bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tsh   <= '1;
      tcnt  <= '0;
      tbits <= '0;
      rbuf  <= '0;
      rleft <= '0;
    end else if (tx_load) begin
      tsh   <= {1'b1, tx_byte, 1'b0};
      tcnt  <= '0;
      tbits <= 4'd10;
      rbuf  <= ld_buf;
      rleft <= ld_left;
    end else if (tbits != 4'd0) begin
      if (tcnt == FULL) begin
        tcnt  <= '0;
        tsh   <= {1'b1, tsh[9:1]};
        tbits <= tbits - 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench: frames go in on rx, bus and tx
// monitors compare against a queue-based reference.
module tb_uart_bus_master;
  import uart_bus_master_pkg::*;

  localparam int CLK_DIV  = 16;
  localparam int FRAME_TO = 3000;
  localparam int BUS_TO   = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        tx;
  logic        valid;
  logic        ready = 1'b0;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata = '0;
  logic        busy;

  uart_bus_master #(
    .CLK_DIV      (CLK_DIV),
    .FRAME_TIMEOUT(FRAME_TO),
    .BUS_TIMEOUT  (BUS_TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .tx   (tx),
    .valid(valid),
    .ready(ready),
    .wstrb(wstrb),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // kind: 0 normal, 1 bus timeout, 2 reset abort, 3 unexpected
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          lat;
    int          kind;
    logic [31:0] rd;
  } bus_t;

  typedef struct {
    logic [7:0] b;
    bit         first_rdy;
    bit         gap;
    bit         last;
  } txe_t;

  bus_t exp_bus[$];
  txe_t exp_tx[$];

  int total   = 0;
  int bad     = 0;
  int cyc     = 0;
  int rdy_cyc = -1;
  bit in_acc  = 0;
  int vcnt    = 0;
  bus_t cur;

  function automatic void check(string n, logic [31:0] act,
                                logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder and checker
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      in_acc = 0;
      ready  = 1'b0;
    end else if (valid === 1'b1) begin
      if (!in_acc) begin
        check("bus_expected", exp_bus.size() != 0, 1);
        if (exp_bus.size() != 0) cur = exp_bus.pop_front();
        else cur.kind = 3;
        in_acc = 1;
        vcnt   = 0;
      end
      vcnt++;
      if (cur.kind != 3) begin
        check("addr", addr, cur.a);
        check("wstrb", wstrb, cur.s);
        if (cur.s == 4'hF) check("wdata", wdata, cur.d);
      end
      if (cur.kind == 0 && vcnt == cur.lat + 1) begin
        ready   = 1'b1;
        rdata   = cur.rd;
        rdy_cyc = cyc;
      end else begin
        ready = 1'b0;
        rdata = $urandom;
      end
    end else begin
      if (in_acc && cur.kind < 2)
        check("valid_len", vcnt,
              (cur.kind == 1) ? BUS_TO : cur.lat + 1);
      in_acc = 0;
      ready  = 1'b0;
    end
  end

  // Serial response monitor
  initial begin : txmon
    int st;
    int prev_st;
    logic [7:0] b;
    txe_t e;
    prev_st = -100000;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        st = cyc;
        repeat (CLK_DIV / 2) @(negedge clk);
        check("tx_start", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        check("tx_stop", tx, 1);
        check("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
          e = exp_tx.pop_front();
          check("tx_byte", b, e.b);
          if (e.first_rdy) check("tx_latency", st, rdy_cyc + 1);
          if (e.gap) check("tx_gap", st - prev_st, 10 * CLK_DIV);
          if (e.last) begin
            check("busy_in_stop", busy, 1);
            repeat (CLK_DIV / 2) @(negedge clk);
            check("busy_end", busy, 0);
          end
        end
        prev_st = st;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  // Reference: what the bridge must do for one frame
  task automatic run_frame(input logic [7:0] op,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input int lat,
                           input int kind,
                           input logic [31:0] rd);
    bus_t e;
    txe_t t;
    logic [7:0] rsp[$];
    bit legal;
    legal = (op == OP_READ) || (op == OP_WRITE);
    if (legal) begin
      e.a    = a;
      e.d    = d;
      e.s    = (op == OP_WRITE) ? 4'hF : 4'h0;
      e.lat  = lat;
      e.kind = kind;
      e.rd   = rd;
      exp_bus.push_back(e);
      if (kind == 1) rsp.push_back(RSP_ERR);
      else if (kind == 0 && op == OP_WRITE) rsp.push_back(RSP_OK);
      else if (kind == 0)
        for (int i = 0; i < 4; i++) rsp.push_back(rd[8*i +: 8]);
    end else begin
      rsp.push_back(RSP_BAD);
    end
    foreach (rsp[i]) begin
      t.b         = rsp[i];
      t.first_rdy = (i == 0) && legal && (kind == 0);
      t.gap       = (i != 0);
      t.last      = (i == rsp.size() - 1);
      exp_tx.push_back(t);
    end
    send_byte(op, 1'b1);
    if (legal)
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    if (op == OP_WRITE)
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  task automatic wait_idle(input string n);
    int k;
    k = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0 ||
            busy !== 1'b0 || in_acc) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check(n, k < 20000, 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0]  op;
    logic [31:0] a, d, rd;
    int r, k;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_valid", valid, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    run_frame(OP_WRITE, 32'h2000_0010, 32'hDEAD_BEEF, 3, 0, 0);
    wait_idle("write_done");
    run_frame(OP_READ, 32'h1000_0004, 0, 1, 0, 32'h1234_5678);
    wait_idle("read_done");
    run_frame(OP_READ, 32'h0000_0100, 0, 0, 1, 0);
    wait_idle("bus_timeout_done");
    repeat (50) @(negedge clk);

    run_frame(8'hA5, 0, 0, 0, 0, 0);
    wait_idle("badop_done");
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CLK_DIV) @(negedge clk);
    check("glitch_no_byte", busy, 0);

    send_byte(OP_WRITE, 1'b1);
    send_byte(8'h00, 1'b1);
    check("frame_open", busy, 1);
    repeat (FRAME_TO + 100) @(negedge clk);
    check("frame_timeout_idle", busy, 0);
    run_frame(OP_READ, 32'h0000_0040, 0, 2, 0, 32'hCAFE_F00D);
    wait_idle("after_ftimeout");

    send_byte(OP_READ, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (4) @(negedge clk);
    check("frame_err_abort", busy, 0);
    repeat (2 * CLK_DIV) @(negedge clk);
    run_frame(OP_READ, 32'h0000_0080, 0, 0, 0, 32'h0BAD_F00D);
    wait_idle("after_frame_err");

    run_frame(OP_READ, 32'h3000_0000, 0, 0, 2, 0);
    k = 0;
    while (valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_test_valid", valid, 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_async_valid", valid, 0);
    check("rst_async_tx", tx, 1);
    check("rst_async_addr", addr, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    run_frame(OP_READ, 32'h4000_0008, 0, 1, 0, 32'h8765_4321);
    wait_idle("after_reset");

    for (int n = 0; n < 8; n++) begin
      r  = $urandom_range(0, 9);
      a  = $urandom;
      d  = $urandom;
      rd = $urandom;
      if (r < 4) op = OP_WRITE;
      else if (r < 8) op = OP_READ;
      else begin
        op = 8'($urandom_range(0, 255));
        if (op == OP_READ || op == OP_WRITE) op = 8'h00;
      end
      run_frame(op, a, d, $urandom_range(0, 6), 0, rd);
      wait_idle("rand_done");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Serial debug/loader bridge and bus initiator for the on-chip valid/ready memory bus.
- Receives command frames on an 8N1 serial line and issues single 32-bit bus reads/writes.
- Returns results over serial. Lets a host PC peek/poke memory and peripherals before the CPU runs.

Parameters:
- CLK_DIV, 104, clock cycles per serial bit (fixed at build time, >= 4)
- FRAME_TIMEOUT, 100000, max idle cycles between bytes inside a frame before the frame is discarded
- BUS_TIMEOUT, 1024, max cycles valid is held without ready before the access is abandoned

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  serial input, idle high, asynchronous to clk
- tx  out  1  serial output, idle high
- valid  out  1  bus request
- ready  in  1  bus completion, one-cycle pulse or level
- wstrb  out  4  4'hF on write, 4'h0 on read
- addr  out  32  bus address
- wdata  out  32  write data
- rdata  in  32  read data, sampled in the ready cycle
- busy  out  1  high from first opcode byte until last response bit sent

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: tx=1, valid=0, wstrb=0, addr=0, wdata=0, busy=0. Receiver, FSM and counters clear. Reset mid-frame or mid-access drops valid immediately, and the frame is lost.
- Receiver:
  - rx passes through a 2-flop synchronizer.
  - A falling edge in RX_IDLE starts a bit counter. Sample at CLK_DIV/2 to confirm the start bit; a high sample returns to RX_IDLE as a glitch.
  - Then 8 data bits, LSB first, each sampled CLK_DIV later, followed by the stop bit.
  - Stop bit = 0 is a framing error: the byte is discarded and any in-progress frame is aborted.
  - A good byte produces a one-cycle byte_valid.
- Command frames: byte 0 is the opcode, then address bytes LSB first.
  - 0x52 'R': 4 address bytes.
  - 0x57 'W': 4 address bytes, then 4 data bytes LSB first.
  - Any other opcode: respond 0x3F '?', then return to IDLE.
- FSM states:
  - IDLE: a byte arrives; decode the opcode.
  - GET_ADDR: collect 4 bytes with a 2-bit index.
  - GET_DATA: writes only, collect 4 bytes.
  - BUS: drive the access.
  - RESP: serialize the response bytes.
  - Then back to IDLE.
- Frame timeout: in GET_ADDR/GET_DATA, a gap counter resets on each byte. Reaching FRAME_TIMEOUT returns to IDLE silently with nothing issued.
- Bus handshake:
  - valid rises the cycle after the last frame byte.
  - addr, wdata and wstrb are stable while valid=1.
  - valid drops the cycle after ready is sampled high; ready while valid=0 is ignored.
  - Reads latch rdata in the ready cycle. Latency from ready to the first tx start bit is 1 cycle.
  - If BUS_TIMEOUT cycles elapse with no ready, drop valid and respond 0x45 'E' only.
- Responses:
  - Write OK: 0x4B 'K'.
  - Read OK: 4 data bytes LSB first.
- Transmitter:
  - 10-bit shift register {1, byte, 0}, shifted every CLK_DIV cycles.
  - Bytes go back to back, with no extra idle bits between them.
- RX during BUS/RESP: bytes received are discarded (half-duplex command protocol) and do not abort the current operation.
- Counters: bit counters are sized with $clog2(CLK_DIV). Timeout counters saturate and do not wrap.

Decomposition:
- Package uart_bus_master_pkg:
  - opcode constants OP_READ=8'h52, OP_WRITE=8'h57
  - response constants RSP_OK=8'h4B, RSP_ERR=8'h45, RSP_BAD=8'h3F
  - FSM state typedef
- Sub-module uart_rx_byte: synchronizer, start detect, sampling, framing check. Outputs byte_valid, byte_data, frame_err.
- The transmitter and command FSM stay in the top module.

Test Plan (bench CLK_DIV=16):
- Write: send 57 10 00 00 20 EF BE AD DE. Expect one bus access with addr=0x2000_0010, wdata=0xDEADBEEF, wstrb=F; ready after 3 cycles; tx returns 4B; busy low after its stop bit.
- Read: send 52 04 00 00 10, bus returns rdata=0x12345678 with ready after 1 cycle. Expect wstrb=0 and tx bytes 78 56 34 12 back to back.
- Bus timeout: read with ready held low. Expect valid high exactly BUS_TIMEOUT cycles, then dropped, tx 45, no further bus activity.
- Bad opcode and glitch: send 0xA5 → tx 3F, valid never asserted. A 3-cycle low pulse on rx produces no byte.
- Frame timeout and framing error:
  - Send 57 00 then idle FRAME_TIMEOUT cycles, then a full read frame. Only the read is issued.
  - A byte with stop bit 0 mid-frame aborts the frame, with no response.
- Async reset asserted while valid=1 mid-access: valid and tx return to 0/1 combinationally on reset. After release, a fresh read frame completes normally.
